// File: rtl/serial_add_sub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package serial_add_sub_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned CNT_W         = $clog2(DEFAULT_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell used by the serial datapath.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  assign sum_o  = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial WIDTH-bit add/subtract controller driving one full_adder, LSB first.
// Define SERIAL_ADD_SUB_OVF_EN to enable the signed overflow flag.
module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             cout_o,
  output logic             overflow_o
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] result_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic             carry_q;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;
  logic             fa_sum;
  logic             fa_cout;
  logic             last_bit_c;

  full_adder u_fa (
    .a_i    (a_sh_q[0]),
    .b_i    (b_sh_q[0]),
    .cin_i  (carry_q),
    .sum_o  (fa_sum),
    .cout_o (fa_cout)
  );

  always_comb begin
    cnt_d      = CW'(cnt_q + 1'b1);
    last_bit_c = (cnt_q == CW'(WIDTH - 1));
  end

  // Control FSM and bit datapath; subtraction is A + ~B + 1.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            a_sh_q  <= a_i;
            b_sh_q  <= b_i ^ {WIDTH{sub_i}};
            carry_q <= sub_i;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          result_q <= {fa_sum, result_q[WIDTH-1:1]};
          a_sh_q   <= {1'b0, a_sh_q[WIDTH-1:1]};
          b_sh_q   <= {1'b0, b_sh_q[WIDTH-1:1]};
          carry_q  <= fa_cout;
          cnt_q    <= cnt_d;
          if (last_bit_c) begin
            cout_q  <= fa_cout;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;
  assign cout_o   = cout_q;

`ifdef SERIAL_ADD_SUB_OVF_EN
  logic msb_cin_q;
  logic ovf_q;

  // Carry into the MSB is the cell carry-out while processing bit WIDTH-2.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      msb_cin_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else if (state_q == ST_RUN) begin
      if (cnt_q == CW'(WIDTH - 2)) begin
        msb_cin_q <= fa_cout;
      end
      if (last_bit_c) begin
        ovf_q <= msb_cin_q ^ fa_cout;
      end
    end
  end

  assign overflow_o = ovf_q;
`else
  assign overflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed self-checking bench for serial_add_sub.
module tb_serial_add_sub;

  localparam int unsigned W = 8;

`ifdef SERIAL_ADD_SUB_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_add_sub #(.WIDTH(W)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .sub_i      (sub),
    .a_i        (a),
    .b_i        (b),
    .busy_o     (busy),
    .done_o     (done),
    .result_o   (result),
    .cout_o     (cout),
    .overflow_o (overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one operation from IDLE and waits (bounded) for done.
  // cyc = cycle number of done relative to the start edge; busy_ok = busy seen high every RUN cycle.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                        output int cyc, output logic busy_ok);
    tick();
    a = av; b = bv; sub = sv; start = 1'b1;
    tick();
    start = 1'b0; a = '0; b = '0; sub = 1'b0;
    cyc = 1;
    busy_ok = 1'b1;
    while (!done && cyc < 40) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1; a = 8'd9; b = 8'd9;
    repeat (3) tick();
    start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (result !== 8'd0) begin errors++; $display("FAIL reset_result got %0d exp 0", result); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout got %b exp 0", cout); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", overflow); end
    rst = 1'b0;
  endtask

  task automatic test_add();
    int cyc;
    logic bok;
    run_op(8'd5, 8'd3, 1'b0, cyc, bok);
    checks++; if (cyc != W + 1) begin errors++; $display("FAIL add5_3_latency got %0d exp %0d", cyc, W + 1); end
    checks++; if (bok !== 1'b1) begin errors++; $display("FAIL add5_3_busy got %b exp 1", bok); end
    checks++; if (result !== 8'd8) begin errors++; $display("FAIL add5_3_result got %0d exp 8", result); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL add5_3_cout got %b exp 0", cout); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL add5_3_ovf got %b exp 0", overflow); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL add5_3_busy_done got %b exp 0", busy); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL add5_3_done_pulse got %b exp 0", done); end
    checks++; if (result !== 8'd8) begin errors++; $display("FAIL add5_3_hold got %0d exp 8", result); end

    run_op(8'd200, 8'd100, 1'b0, cyc, bok);
    checks++; if (result !== 8'd44) begin errors++; $display("FAIL add200_100_result got %0d exp 44", result); end
    checks++; if (cout !== 1'b1) begin errors++; $display("FAIL add200_100_cout got %b exp 1", cout); end

    run_op(8'd127, 8'd1, 1'b0, cyc, bok);
    checks++; if (result !== 8'd128) begin errors++; $display("FAIL add127_1_result got %0d exp 128", result); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL add127_1_cout got %b exp 0", cout); end
    checks++; if (overflow !== OVF_ON) begin errors++; $display("FAIL add127_1_ovf got %b exp %b", overflow, OVF_ON); end
  endtask

  task automatic test_sub();
    int cyc;
    logic bok;
    run_op(8'd5, 8'd3, 1'b1, cyc, bok);
    checks++; if (result !== 8'd2) begin errors++; $display("FAIL sub5_3_result got %0d exp 2", result); end
    checks++; if (cout !== 1'b1) begin errors++; $display("FAIL sub5_3_cout got %b exp 1", cout); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL sub5_3_ovf got %b exp 0", overflow); end

    run_op(8'd3, 8'd5, 1'b1, cyc, bok);
    checks++; if (result !== 8'd254) begin errors++; $display("FAIL sub3_5_result got %0d exp 254", result); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL sub3_5_cout got %b exp 0", cout); end

    run_op(8'd128, 8'd1, 1'b1, cyc, bok);
    checks++; if (result !== 8'd127) begin errors++; $display("FAIL sub128_1_result got %0d exp 127", result); end
    checks++; if (cout !== 1'b1) begin errors++; $display("FAIL sub128_1_cout got %b exp 1", cout); end
    checks++; if (overflow !== OVF_ON) begin errors++; $display("FAIL sub128_1_ovf got %b exp %b", overflow, OVF_ON); end
  endtask

  task automatic test_ignore_start();
    int   ndone = 0;
    logic busy_after = 1'b0;
    tick();
    a = 8'd5; b = 8'd3; sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    // Now in cycle 1 of the operation.
    for (int c = 1; c <= W + 5; c++) begin
      if (done === 1'b1) ndone++;
      if (c >= W + 2 && busy !== 1'b0) busy_after = 1'b1;
      if (c == 3 || c == W + 1) begin
        start = 1'b1; a = 8'd99; b = 8'd1; sub = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0; a = '0; b = '0; sub = 1'b0;
    checks++; if (ndone != 1) begin errors++; $display("FAIL ignore_done_count got %0d exp 1", ndone); end
    checks++; if (result !== 8'd8) begin errors++; $display("FAIL ignore_result got %0d exp 8", result); end
    checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL ignore_restart got %b exp 0", busy_after); end
  endtask

  task automatic test_reset_mid_run();
    int   cyc;
    logic bok;
    int   ndone = 0;
    tick();
    a = 8'd50; b = 8'd60; sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    // Cycle 4: assert reset, with start also high to show it is not taken.
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b exp 0", done); end
    checks++; if (result !== 8'd0) begin errors++; $display("FAIL midrst_result got %0d exp 0", result); end
    checks++; if ({cout, overflow} !== 2'b00) begin errors++; $display("FAIL midrst_flags got %b exp 00", {cout, overflow}); end
    for (int i = 0; i < W + 4; i++) begin
      if (done === 1'b1 || busy === 1'b1) ndone++;
      tick();
    end
    checks++; if (ndone != 0) begin errors++; $display("FAIL midrst_activity got %0d exp 0", ndone); end
    run_op(8'd10, 8'd20, 1'b0, cyc, bok);
    checks++; if (result !== 8'd30) begin errors++; $display("FAIL midrst_next_result got %0d exp 30", result); end
    checks++; if (cyc != W + 1) begin errors++; $display("FAIL midrst_next_latency got %0d exp %0d", cyc, W + 1); end
  endtask

  task automatic test_back_to_back();
    int t_done[$];
    int bad = 0;
    int nbad_res = 0;
    tick();
    a = 8'd7; b = 8'd9; sub = 1'b1; start = 1'b1;
    for (int t = 0; t < 4 * (W + 2) + 2; t++) begin
      tick();
      if (done === 1'b1) begin
        t_done.push_back(t);
        if (result !== 8'd254) nbad_res++;
      end
    end
    start = 1'b0; a = '0; b = '0; sub = 1'b0;
    repeat (W + 3) tick();
    for (int i = 1; i < t_done.size(); i++) begin
      if (t_done[i] - t_done[i-1] != int'(W + 2)) bad++;
    end
    checks++; if (t_done.size() != 4) begin errors++; $display("FAIL b2b_done_count got %0d exp 4", t_done.size()); end
    checks++; if (bad != 0) begin errors++; $display("FAIL b2b_spacing bad_gaps %0d exp 0", bad); end
    checks++; if (nbad_res != 0) begin errors++; $display("FAIL b2b_result wrong_results %0d exp 0", nbad_res); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_ignore_start();
    test_reset_mid_run();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_add_sub.md
# serial_add_sub

Bit-serial 8-bit adder/subtractor controller that drives a single `full_adder` cell one bit per clock, LSB first. It sits directly upstream of the `full_adder` cell:
- latches the operands;
- applies the subtract inversion to B and seeds the carry;
- shifts operand bits into the cell and registers its carry-out between cycles;
- collects the sum bits into a result register.

A start/done handshake delivers the result and flags to the consumer.

## Interface
- `WIDTH`, default 8: operand and result width in bits; must be ≥ 2.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request to begin an operation; sampled only in IDLE.
- `sub`  in  1  operation select, sampled with `start`: 0 = A+B, 1 = A−B.
- `a`  in  WIDTH  operand A, sampled with `start`.
- `b`  in  WIDTH  operand B, sampled with `start`.
- `busy`  out  1  high while in RUN.
- `done`  out  1  single-cycle pulse; result and flags are valid in this cycle.
- `result`  out  WIDTH  sum or difference modulo 2^WIDTH.
- `cout`  out  1  final carry. For subtraction, 1 means no borrow.
- `overflow`  out  1  signed overflow flag (see Configuration).

## Operation
- States: IDLE, RUN, DONE.
- IDLE → RUN when `start` = 1. On that edge the block loads:
  - `a_sh` ← `a`;
  - `b_sh` ← `b` XOR {WIDTH{`sub`}};
  - carry register ← `sub`;
  - bit counter ← 0.
- RUN, every cycle:
  - The full-adder inputs are `a_sh[0]`, `b_sh[0]` and the carry register.
  - `sum` is shifted into `result` at the MSB; `result` shifts right.
  - `a_sh` and `b_sh` shift right; the carry register ← `cout` of the cell; the counter increments.
- RUN → DONE on the edge where counter = WIDTH−1, which processes the last bit.
- DONE → IDLE unconditionally after one cycle. `start` in DONE is ignored.
- `start` is ignored while in RUN. Operands change only at accepted starts.
- The `cout` output is the carry register after the last bit.
- `overflow` = (carry into the MSB bit) XOR (carry out of the MSB bit). The carry into the MSB bit is captured on the edge where counter = WIDTH−2.
- `result`, `cout` and `overflow` hold their values from DONE through IDLE until the next accepted start. During RUN, `result` contains partial data and is not valid.

## Timing
- Reset: state IDLE; the following are all 0:
  - `busy`, `done`, `result`, `cout`, `overflow`;
  - the shift registers, carry register and counter.
- Reset asserted mid-RUN aborts the operation. No `done` is produced, and `start` is not accepted until after `rst` is released.
- Cycle numbering: `start` is sampled at edge 0.
  - Cycles 1..WIDTH: `busy` = 1, one bit is processed per cycle.
  - Cycle WIDTH+1: `done` = 1, `busy` = 0.
  - The earliest next start is sampled at edge WIDTH+2.
- Latency is WIDTH+1 cycles from the start edge to `done`. Throughput is one operation per WIDTH+2 cycles.
- `done` is high for exactly one cycle per accepted start.

## Configuration
- `SERIAL_ADD_SUB_OVF_EN` defined:
  - MSB carry-in capture logic is present;
  - `overflow` behaves as specified above.
- `SERIAL_ADD_SUB_OVF_EN` undefined:
  - the capture flop is removed;
  - `overflow` is tied to 0;
  - all other behaviour is identical.

## Structure
- Shared package holds:
  - the state enum (IDLE, RUN, DONE);
  - the default WIDTH constant;
  - the counter width, $clog2(WIDTH).
- One sub-module: instantiate the existing `full_adder` cell once for the bit datapath. No other arithmetic is inferred.

## Test plan
- Add 5 + 3 → `done` at cycle 9, `result` = 8, `cout` = 0, `overflow` = 0.
- Add 200 + 100 → `result` = 44, `cout` = 1. Add 127 + 1 → `result` = 128, `overflow` = 1 (0 with the macro undefined).
- Sub 5 − 3 → `result` = 2, `cout` = 1. Sub 3 − 5 → `result` = 254, `cout` = 0. Sub 128 − 1 → `result` = 127, `overflow` = 1.
- `start` pulsed with new operands at cycles 3 and WIDTH+1 of an operation → both ignored; the first result is unchanged and exactly one `done` pulse occurs.
- `rst` asserted at cycle 4 of RUN → the next cycle is IDLE with all outputs 0 and no `done`; a following 10 + 20 → `result` = 30.
- Back-to-back operations with `start` held high → a new start is accepted every WIDTH+2 cycles, and `done` pulses are spaced WIDTH+2 cycles apart.
